// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the I-cache/D-cache to memory-port arbiter.
package mem_bus_arbiter_pkg;

    localparam int XLEN      = 32;
    localparam int MEM_TAG_W = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_command_e;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } mem_size_e;

    // Owner encoding stored per outstanding tag.
    localparam logic ARB_REQ_IC = 1'b0;
    localparam logic ARB_REQ_DC = 1'b1;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_tag_table.sv
// Per-tag owner table: allocate port records load owners, lookup port routes and frees them.
module arb_tag_table
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_TAGS = 16,
    parameter int TAG_W    = MEM_TAG_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_en,
    input  logic [TAG_W-1:0] alloc_tag,
    input  logic             alloc_is_dc,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             lookup_hit,
    output logic             lookup_is_dc
);

    logic [NUM_TAGS-1:0] owner_valid_q, owner_valid_d;
    logic [NUM_TAGS-1:0] owner_is_dc_q, owner_is_dc_d;

    always_comb begin
        lookup_hit   = 1'b0;
        lookup_is_dc = 1'b0;
        if ((lookup_tag != '0) && (int'(lookup_tag) < NUM_TAGS)) begin
            lookup_hit   = owner_valid_q[lookup_tag];
            lookup_is_dc = owner_is_dc_q[lookup_tag];
        end
    end

    // Free first, then allocate, so a tag returned and re-issued in one cycle stays valid.
    always_comb begin
        owner_valid_d = owner_valid_q;
        owner_is_dc_d = owner_is_dc_q;
        if (lookup_hit) begin
            owner_valid_d[lookup_tag] = 1'b0;
        end
        if (alloc_en && (alloc_tag != '0) && (int'(alloc_tag) < NUM_TAGS)) begin
            owner_valid_d[alloc_tag] = 1'b1;
            owner_is_dc_d[alloc_tag] = alloc_is_dc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_valid_q <= '0;
            owner_is_dc_q <= '0;
        end else begin
            owner_valid_q <= owner_valid_d;
            owner_is_dc_q <= owner_is_dc_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory-port arbiter with D-cache priority and I-cache anti-starvation.
// Define ARB_STATS_EN to add saturating grant/stall/unknown-tag counters.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_TAGS     = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           ic2arb_command,
    input  logic [XLEN-1:0]      ic2arb_addr,
    input  logic [1:0]           ic2arb_size,
    output logic [MEM_TAG_W-1:0] arb2ic_response,
    output logic [63:0]          arb2ic_data,
    output logic [MEM_TAG_W-1:0] arb2ic_tag,
    input  logic [1:0]           dc2arb_command,
    input  logic [XLEN-1:0]      dc2arb_addr,
    input  logic [63:0]          dc2arb_data,
    input  logic [1:0]           dc2arb_size,
    output logic [MEM_TAG_W-1:0] arb2dc_response,
    output logic [63:0]          arb2dc_data,
    output logic [MEM_TAG_W-1:0] arb2dc_tag,
    output logic [1:0]           proc2mem_command,
    output logic [XLEN-1:0]      proc2mem_addr,
    output logic [63:0]          proc2mem_data,
    output logic [1:0]           proc2mem_size,
    input  logic [MEM_TAG_W-1:0] mem2proc_response,
    input  logic [63:0]          mem2proc_data,
    input  logic [MEM_TAG_W-1:0] mem2proc_tag
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]          arb_stats_ic_grants,
    output logic [31:0]          arb_stats_dc_grants,
    output logic [31:0]          arb_stats_ic_stall,
    output logic [31:0]          arb_stats_unknown
`endif
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic ic_req, dc_req, grant_ic, grant_dc;
    logic alloc_en, lookup_hit, lookup_is_dc;

    assign ic_req   = (ic2arb_command != BUS_NONE);
    assign dc_req   = (dc2arb_command != BUS_NONE);
    assign grant_dc = dc_req && !(ic_req && (starve_cnt_q >= STARVE_MAX));
    assign grant_ic = ic_req && !grant_dc;

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        proc2mem_size    = '0;
        arb2ic_response  = '0;
        arb2dc_response  = '0;
        if (grant_dc) begin
            proc2mem_command = dc2arb_command;
            proc2mem_addr    = dc2arb_addr;
            proc2mem_data    = dc2arb_data;
            proc2mem_size    = dc2arb_size;
            arb2dc_response  = mem2proc_response;
        end else if (grant_ic) begin
            proc2mem_command = ic2arb_command;
            proc2mem_addr    = ic2arb_addr;
            proc2mem_size    = ic2arb_size;
            arb2ic_response  = mem2proc_response;
        end
    end

    // Only loads get data back, so only accepted loads claim a tag.
    assign alloc_en = (proc2mem_command == BUS_LOAD) && (mem2proc_response != '0);

    arb_tag_table #(
        .NUM_TAGS (NUM_TAGS),
        .TAG_W    (MEM_TAG_W)
    ) u_tag_table (
        .clock        (clock),
        .reset        (reset),
        .alloc_en     (alloc_en),
        .alloc_tag    (mem2proc_response),
        .alloc_is_dc  (grant_dc ? ARB_REQ_DC : ARB_REQ_IC),
        .lookup_tag   (mem2proc_tag),
        .lookup_hit   (lookup_hit),
        .lookup_is_dc (lookup_is_dc)
    );

    always_comb begin
        arb2ic_data = '0;
        arb2ic_tag  = '0;
        arb2dc_data = '0;
        arb2dc_tag  = '0;
        if (lookup_hit) begin
            if (lookup_is_dc == ARB_REQ_DC) begin
                arb2dc_data = mem2proc_data;
                arb2dc_tag  = mem2proc_tag;
            end else begin
                arb2ic_data = mem2proc_data;
                arb2ic_tag  = mem2proc_tag;
            end
        end
    end

    always_comb begin
        starve_cnt_d = '0;
        if (ic_req && !grant_ic) begin
            starve_cnt_d = (starve_cnt_q >= STARVE_MAX) ? STARVE_MAX : starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] ic_grants_q, ic_grants_d;
    logic [31:0] dc_grants_q, dc_grants_d;
    logic [31:0] ic_stall_q, ic_stall_d;
    logic [31:0] unknown_q, unknown_d;

    always_comb begin
        ic_grants_d = sat_inc32(ic_grants_q, grant_ic);
        dc_grants_d = sat_inc32(dc_grants_q, grant_dc);
        ic_stall_d  = sat_inc32(ic_stall_q, ic_req && !grant_ic);
        unknown_d   = sat_inc32(unknown_q, (mem2proc_tag != '0) && !lookup_hit);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ic_grants_q <= '0;
            dc_grants_q <= '0;
            ic_stall_q  <= '0;
            unknown_q   <= '0;
        end else begin
            ic_grants_q <= ic_grants_d;
            dc_grants_q <= dc_grants_d;
            ic_stall_q  <= ic_stall_d;
            unknown_q   <= unknown_d;
        end
    end

    assign arb_stats_ic_grants = ic_grants_q;
    assign arb_stats_dc_grants = dc_grants_q;
    assign arb_stats_ic_stall  = ic_stall_q;
    assign arb_stats_unknown   = unknown_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized and directed bench for mem_bus_arbiter against a behavioural owner/priority model.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int NT = 16;
    localparam int SL = 8;
    localparam int OWN_NONE = -1;
    localparam int OWN_IC   = 0;
    localparam int OWN_DC   = 1;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  ic2arb_command, dc2arb_command, ic2arb_size, dc2arb_size;
    logic [31:0] ic2arb_addr, dc2arb_addr;
    logic [63:0] dc2arb_data, mem2proc_data, arb2ic_data, arb2dc_data, proc2mem_data;
    logic [3:0]  arb2ic_response, arb2ic_tag, arb2dc_response, arb2dc_tag;
    logic [1:0]  proc2mem_command, proc2mem_size;
    logic [31:0] proc2mem_addr;
    logic [3:0]  mem2proc_response, mem2proc_tag;

    int n_tests = 0;
    int n_fail  = 0;
    int m_owner[NT];
    int m_starve;

    mem_bus_arbiter #(.NUM_TAGS(NT), .STARVE_LIMIT(SL)) dut (
        .clock             (clock),
        .reset             (reset),
        .ic2arb_command    (ic2arb_command),
        .ic2arb_addr       (ic2arb_addr),
        .ic2arb_size       (ic2arb_size),
        .arb2ic_response   (arb2ic_response),
        .arb2ic_data       (arb2ic_data),
        .arb2ic_tag        (arb2ic_tag),
        .dc2arb_command    (dc2arb_command),
        .dc2arb_addr       (dc2arb_addr),
        .dc2arb_data       (dc2arb_data),
        .dc2arb_size       (dc2arb_size),
        .arb2dc_response   (arb2dc_response),
        .arb2dc_data       (arb2dc_data),
        .arb2dc_tag        (arb2dc_tag),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .proc2mem_size     (proc2mem_size),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        ic2arb_command = BUS_NONE; ic2arb_addr = '0; ic2arb_size = '0;
        dc2arb_command = BUS_NONE; dc2arb_addr = '0; dc2arb_size = '0; dc2arb_data = '0;
        mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NT; i++) m_owner[i] = OWN_NONE;
        m_starve = 0;
    endtask

    // Who the model says gets the bus this cycle.
    function automatic int model_grant();
        bit ic = (ic2arb_command != BUS_NONE);
        bit dc = (dc2arb_command != BUS_NONE);
        if (dc && !(ic && m_starve >= SL)) return OWN_DC;
        if (ic) return OWN_IC;
        return OWN_NONE;
    endfunction

    task automatic check_outputs();
        int g = model_grant();
        int own = (mem2proc_tag != 0) ? m_owner[mem2proc_tag] : OWN_NONE;
        check_val("cmd",  proc2mem_command, g == OWN_DC ? dc2arb_command : g == OWN_IC ? ic2arb_command : 2'd0);
        check_val("addr", proc2mem_addr,    g == OWN_DC ? dc2arb_addr : g == OWN_IC ? ic2arb_addr : 32'd0);
        check_val("size", proc2mem_size,    g == OWN_DC ? dc2arb_size : g == OWN_IC ? ic2arb_size : 2'd0);
        check_val("wdata", proc2mem_data,   g == OWN_DC ? dc2arb_data : 64'd0);
        check_val("ic_resp", arb2ic_response, g == OWN_IC ? mem2proc_response : 4'd0);
        check_val("dc_resp", arb2dc_response, g == OWN_DC ? mem2proc_response : 4'd0);
        check_val("ic_tag",  arb2ic_tag,  own == OWN_IC ? mem2proc_tag : 4'd0);
        check_val("ic_data", arb2ic_data, own == OWN_IC ? mem2proc_data : 64'd0);
        check_val("dc_tag",  arb2dc_tag,  own == OWN_DC ? mem2proc_tag : 4'd0);
        check_val("dc_data", arb2dc_data, own == OWN_DC ? mem2proc_data : 64'd0);
    endtask

    task automatic model_update();
        int g = model_grant();
        logic [1:0] gcmd = (g == OWN_DC) ? dc2arb_command : (g == OWN_IC) ? ic2arb_command : 2'd0;
        if (mem2proc_tag != 0) m_owner[mem2proc_tag] = OWN_NONE;
        if (gcmd == BUS_LOAD && mem2proc_response != 0) m_owner[mem2proc_response] = g;
        if (ic2arb_command != BUS_NONE && g != OWN_IC) m_starve = (m_starve >= SL) ? SL : m_starve + 1;
        else m_starve = 0;
    endtask

    // Inputs are driven 1ns after posedge; checks happen on the falling edge.
    task automatic step();
        @(negedge clock);
        check_outputs();
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_cmd"},  proc2mem_command, 2'd0);
        check_val({tag, "_addr"}, proc2mem_addr, 32'd0);
        check_val({tag, "_icr"},  arb2ic_response, 4'd0);
        check_val({tag, "_dcr"},  arb2dc_response, 4'd0);
        check_val({tag, "_ict"},  arb2ic_tag, 4'd0);
        check_val({tag, "_dct"},  arb2dc_tag, 4'd0);
    endtask

    initial begin
        set_idle();
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_idle("rst");
        reset = 1'b0;
        @(posedge clock); #1;

        // D-cache load alone, tag 3, data return later.
        dc2arb_command = BUS_LOAD; dc2arb_addr = 32'h100; dc2arb_size = WORD; mem2proc_response = 4'd3;
        #1 check_val("t1_resp", arb2dc_response, 4'd3);
        step();
        set_idle(); step();
        mem2proc_tag = 4'd3; mem2proc_data = 64'hDEADBEEF_00000001;
        #1 check_val("t1_tag", arb2dc_tag, 4'd3);
        check_val("t1_data", arb2dc_data, 64'hDEADBEEF_00000001);
        check_val("t1_ictag", arb2ic_tag, 4'd0);
        step();

        // Both request every cycle: eight D-cache grants, then a forced I-cache grant.
        set_idle();
        ic2arb_command = BUS_LOAD; ic2arb_addr = 32'h2000; ic2arb_size = DOUBLE;
        dc2arb_command = BUS_LOAD; dc2arb_addr = 32'h3000; dc2arb_size = DOUBLE;
        mem2proc_response = 4'd9;
        for (int c = 0; c < 10; c++) begin
            #1;
            check_val($sformatf("starve_dc%0d", c), arb2dc_response, (c == 8) ? 4'd0 : 4'd9);
            check_val($sformatf("starve_ic%0d", c), arb2ic_response, (c == 8) ? 4'd9 : 4'd0);
            step();
        end
        set_idle(); mem2proc_tag = 4'd9; step();

        // Accepted store allocates nothing.
        set_idle();
        dc2arb_command = BUS_STORE; dc2arb_addr = 32'h40; dc2arb_data = 64'h1234; mem2proc_response = 4'd5;
        step();
        set_idle(); mem2proc_tag = 4'd5; mem2proc_data = 64'hAAAA;
        #1 check_val("st_dctag", arb2dc_tag, 4'd0);
        check_val("st_ictag", arb2ic_tag, 4'd0);
        step();

        // Tag 7 returns to the D-cache while being re-issued to the I-cache.
        set_idle(); dc2arb_command = BUS_LOAD; dc2arb_addr = 32'h700; mem2proc_response = 4'd7;
        step();
        set_idle(); ic2arb_command = BUS_LOAD; ic2arb_addr = 32'h800; mem2proc_response = 4'd7;
        mem2proc_tag = 4'd7; mem2proc_data = 64'h77;
        #1 check_val("col_dctag", arb2dc_tag, 4'd7);
        check_val("col_ictag", arb2ic_tag, 4'd0);
        check_val("col_icresp", arb2ic_response, 4'd7);
        step();
        set_idle(); mem2proc_tag = 4'd7; mem2proc_data = 64'h78;
        #1 check_val("col_newown", arb2ic_tag, 4'd7);
        step();

        // Memory busy then accepting.
        set_idle(); dc2arb_command = BUS_LOAD; dc2arb_addr = 32'h900; mem2proc_response = 4'd0;
        #1 check_val("busy_resp0", arb2dc_response, 4'd0);
        step();
        mem2proc_response = 4'd2;
        #1 check_val("busy_resp2", arb2dc_response, 4'd2);
        step();
        set_idle(); mem2proc_tag = 4'd2; mem2proc_data = 64'h22;
        #1 check_val("busy_ret", arb2dc_tag, 4'd2);
        step();

        // Reset with tags 1 and 4 outstanding.
        set_idle(); dc2arb_command = BUS_LOAD; mem2proc_response = 4'd1; step();
        set_idle(); ic2arb_command = BUS_LOAD; mem2proc_response = 4'd4; step();
        set_idle();
        #2 reset = 1'b1;
        #1 check_idle("mrst");
        model_reset();
        @(posedge clock); #1 reset = 1'b0;
        mem2proc_tag = 4'd1; mem2proc_data = 64'h11;
        #1 check_val("rst_t1", arb2dc_tag, 4'd0);
        step();
        mem2proc_tag = 4'd4;
        #1 check_val("rst_t4", arb2ic_tag, 4'd0);
        step();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            ic2arb_command    = 2'($urandom_range(0, 2));
            ic2arb_addr       = $urandom;
            ic2arb_size       = 2'($urandom_range(0, 3));
            dc2arb_command    = ($urandom_range(0, 3) == 0) ? 2'd0 : 2'($urandom_range(1, 2));
            dc2arb_addr       = $urandom;
            dc2arb_size       = 2'($urandom_range(0, 3));
            dc2arb_data       = {$urandom, $urandom};
            mem2proc_response = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            mem2proc_tag      = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            mem2proc_data     = {$urandom, $urandom};
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
